// File: rtl/unidade_load_store_if.sv
// Bus bundle between the load/store unit, the CPU datapath and the data RAM.
// master: the load/store unit (answers the CPU, drives the RAM).
// slave : the environment (CPU request side plus the RAM read port).
interface unidade_load_store_if;
  logic        cpu_req;
  logic        cpu_escrita;
  logic [1:0]  cpu_tamanho;
  logic        cpu_sinal;
  logic [31:0] cpu_endereco;
  logic [31:0] cpu_dado;
  logic [31:0] cpu_dado_lido;
  logic        cpu_pronto;
  logic        cpu_ocupado;
  logic        cpu_erro;
  logic [31:0] endereco;
  logic [31:0] dado_escrita;
  logic        MemRead;
  logic        MemWrite;
  logic [31:0] dado_leitura;

  modport master (
    input  cpu_req, cpu_escrita, cpu_tamanho, cpu_sinal, cpu_endereco, cpu_dado, dado_leitura,
    output cpu_dado_lido, cpu_pronto, cpu_ocupado, cpu_erro, endereco, dado_escrita, MemRead, MemWrite
  );

  modport slave (
    output cpu_req, cpu_escrita, cpu_tamanho, cpu_sinal, cpu_endereco, cpu_dado, dado_leitura,
    input  cpu_dado_lido, cpu_pronto, cpu_ocupado, cpu_erro, endereco, dado_escrita, MemRead, MemWrite
  );
endinterface

// File: rtl/unidade_load_store.sv
// Load/store unit: turns CPU byte/half/word requests into word-indexed RAM
// accesses, extends sub-word loads and does sub-word stores as read-modify-write.
// Optional feature macro: LSU_ALINHAMENTO_EN (misaligned accesses are flagged
// and skipped instead of being forced aligned).
module unidade_load_store #(
  parameter int LARGURA_END_MEM = 8
) (
  input  logic clock_i,
  input  logic reset_n_i,
  unidade_load_store_if.master bus
);

  localparam logic [2:0] OCIOSO  = 3'd0;
  localparam logic [2:0] LE      = 3'd1;
  localparam logic [2:0] ESPERA  = 3'd2;
  localparam logic [2:0] ESCREVE = 3'd3;
  localparam logic [2:0] FIM     = 3'd4;
  localparam int         AW      = LARGURA_END_MEM + 2;

  logic [2:0]    estado_q, estado_d;
  logic          escrita_q, sinal_q;
  logic [1:0]    tam_q;
  logic [AW-1:0] end_q, end_al;
  logic [15:0]   dado_q;
  logic [31:0]   lido_q, wdata_q;
  logic [31:0]   lido_ext, mesclado;
  logic [7:0]    byte_sel;
  logic [15:0]   half_sel;
  logic          aceita, desalinhado;

  assign aceita = (estado_q == OCIOSO) && bus.cpu_req;

  // Alignment of the incoming address; without the check, it is forced aligned
  always_comb begin
    end_al      = bus.cpu_endereco[AW-1:0];
    desalinhado = 1'b0;
    if (bus.cpu_tamanho == 2'b01) begin
      desalinhado = bus.cpu_endereco[0];
      end_al[0]   = 1'b0;
    end else if (bus.cpu_tamanho[1]) begin
      desalinhado = |bus.cpu_endereco[1:0];
      end_al[1:0] = 2'b00;
    end
  end

  // Lane select + extension for loads, lane merge for sub-word stores
  always_comb begin
    byte_sel = bus.dado_leitura[{end_q[1:0], 3'b000} +: 8];
    half_sel = bus.dado_leitura[{end_q[1], 4'b0000} +: 16];
    case (tam_q)
      2'b00:   lido_ext = {{24{sinal_q & byte_sel[7]}}, byte_sel};
      2'b01:   lido_ext = {{16{sinal_q & half_sel[15]}}, half_sel};
      default: lido_ext = bus.dado_leitura;
    endcase
    mesclado = bus.dado_leitura;
    if (tam_q == 2'b00) mesclado[{end_q[1:0], 3'b000} +: 8] = dado_q[7:0];
    else                mesclado[{end_q[1], 4'b0000} +: 16] = dado_q;
  end

  // Next-state decode
  always_comb begin
    estado_d = estado_q;
    case (estado_q)
      OCIOSO: if (bus.cpu_req) begin
`ifdef LSU_ALINHAMENTO_EN
        if (desalinhado)                                   estado_d = FIM;
        else
`endif
        if (bus.cpu_escrita && bus.cpu_tamanho[1])         estado_d = ESCREVE;
        else                                               estado_d = LE;
      end
      LE:      estado_d = ESPERA;
      ESPERA:  estado_d = escrita_q ? ESCREVE : FIM;
      ESCREVE: estado_d = FIM;
      FIM:     estado_d = OCIOSO;
      default: estado_d = OCIOSO;
    endcase
  end

  // State, request capture and data registers
  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      estado_q  <= OCIOSO;
      escrita_q <= 1'b0;
      sinal_q   <= 1'b0;
      tam_q     <= 2'b00;
      end_q     <= '0;
      dado_q    <= '0;
      lido_q    <= '0;
      wdata_q   <= '0;
    end else begin
      estado_q <= estado_d;
      if (aceita) begin
        escrita_q <= bus.cpu_escrita;
        sinal_q   <= bus.cpu_sinal;
        tam_q     <= bus.cpu_tamanho;
        end_q     <= end_al;
        dado_q    <= bus.cpu_dado[15:0];
        // word stores skip the read, so their write data is ready now
        wdata_q   <= bus.cpu_dado;
      end
      if (estado_q == ESPERA) begin
        if (escrita_q) wdata_q <= mesclado;
        else           lido_q  <= lido_ext;
      end
    end
  end

`ifdef LSU_ALINHAMENTO_EN
  logic erro_q;
  // Misaligned flag, held until the next accept and shown only in FIM
  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i)  erro_q <= 1'b0;
    else if (aceita) erro_q <= desalinhado;
  end
  assign bus.cpu_erro = erro_q && (estado_q == FIM);
`else
  assign bus.cpu_erro = 1'b0;
`endif

  // Strobes come straight from registered state so reset drops them at once
  assign bus.MemRead       = (estado_q == LE);
  assign bus.MemWrite      = (estado_q == ESCREVE);
  assign bus.cpu_pronto    = (estado_q == FIM);
  assign bus.cpu_ocupado   = (estado_q != OCIOSO);
  assign bus.endereco      = {{(32 - LARGURA_END_MEM){1'b0}}, end_q[AW-1:2]};
  assign bus.dado_escrita  = wdata_q;
  assign bus.cpu_dado_lido = lido_q;

endmodule

// File: tb/tb_unidade_load_store.sv
// Directed bench for unidade_load_store with a behavioural 256x32 RAM.
module tb_unidade_load_store;
  logic clock = 1'b0;
  logic reset_n = 1'b0;
  int   vecs = 0, miss = 0, sobrepos = 0;
  logic [31:0] mem [256];

  unidade_load_store_if bus();
  unidade_load_store #(.LARGURA_END_MEM(8)) dut (
    .clock_i(clock), .reset_n_i(reset_n), .bus(bus)
  );

  always #5 clock = ~clock;

  // RAM: read sampled on rising edge, write on falling edge
  always @(posedge clock) if (bus.MemRead) bus.dado_leitura <= mem[bus.endereco[7:0]];
  always @(negedge clock) if (bus.MemWrite) mem[bus.endereco[7:0]] <= bus.dado_escrita;
  always @(negedge clock) if (bus.MemRead && bus.MemWrite) sobrepos++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      miss++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One access; lat = cycles from accept edge to the pronto cycle (10 = timeout)
  task automatic acesso(input logic esc, input logic [1:0] tam, input logic sin,
                        input logic [31:0] a, input logic [31:0] d,
                        output int lat, output int nrd, output int nwr, output logic erro);
    @(negedge clock);
    bus.cpu_req = 1'b1; bus.cpu_escrita = esc; bus.cpu_tamanho = tam;
    bus.cpu_sinal = sin; bus.cpu_endereco = a; bus.cpu_dado = d;
    @(posedge clock);
    lat = 0; nrd = 0; nwr = 0; erro = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      if (i == 0) begin
        bus.cpu_req = 1'b0; bus.cpu_endereco = 32'hFFFF_FFFF; bus.cpu_dado = 32'h5A5A_5A5A;
        bus.cpu_tamanho = 2'b00; bus.cpu_sinal = ~sin; bus.cpu_escrita = ~esc;
      end
      lat++;
      nrd += int'(bus.MemRead);
      nwr += int'(bus.MemWrite);
      if (bus.cpu_pronto) begin
        erro = bus.cpu_erro;
        break;
      end
    end
  endtask

  initial begin
    int lat, nrd, nwr, acc, npr, pronto_rst;
    logic erro, ocup_ant;
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    bus.cpu_req = 1'b0; bus.cpu_escrita = 1'b0; bus.cpu_tamanho = 2'b00;
    bus.cpu_sinal = 1'b0; bus.cpu_endereco = '0; bus.cpu_dado = '0;

    // Reset state
    repeat (2) @(negedge clock);
    chk("rst_pronto", 32'(bus.cpu_pronto), 32'd0);
    chk("rst_ocupado", 32'(bus.cpu_ocupado), 32'd0);
    chk("rst_memread", 32'(bus.MemRead), 32'd0);
    chk("rst_memwrite", 32'(bus.MemWrite), 32'd0);
    chk("rst_endereco", bus.endereco, 32'd0);
    chk("rst_dado_escrita", bus.dado_escrita, 32'd0);
    chk("rst_dado_lido", bus.cpu_dado_lido, 32'd0);
    chk("rst_erro", 32'(bus.cpu_erro), 32'd0);
    reset_n = 1'b1;

    // Reset in the middle of ESCREVE of a word store to 0x30
    @(negedge clock);
    bus.cpu_req = 1'b1; bus.cpu_escrita = 1'b1; bus.cpu_tamanho = 2'b10;
    bus.cpu_endereco = 32'h30; bus.cpu_dado = 32'h1234_5678;
    @(posedge clock); #1;
    bus.cpu_req = 1'b0;
    chk("abort_memwrite_before", 32'(bus.MemWrite), 32'd1);
    reset_n = 1'b0; #1;
    chk("abort_memwrite", 32'(bus.MemWrite), 32'd0);
    chk("abort_ocupado", 32'(bus.cpu_ocupado), 32'd0);
    chk("abort_endereco", bus.endereco, 32'd0);
    chk("abort_dado_escrita", bus.dado_escrita, 32'd0);
    pronto_rst = 0;
    repeat (2) begin @(negedge clock); pronto_rst += int'(bus.cpu_pronto); end
    reset_n = 1'b1;
    repeat (2) begin @(negedge clock); pronto_rst += int'(bus.cpu_pronto); end
    chk("abort_no_pronto", 32'(pronto_rst), 32'd0);
    chk("abort_write_lost", mem[12], 32'd0);

    // Word store then word load at 0x10
    acesso(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEAD_BEEF, lat, nrd, nwr, erro);
    chk("sw_latency", 32'(lat), 32'd2);
    chk("sw_memread", 32'(nrd), 32'd0);
    chk("sw_memwrite", 32'(nwr), 32'd1);
    chk("sw_lido_unchanged", bus.cpu_dado_lido, 32'd0);
    acesso(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, lat, nrd, nwr, erro);
    chk("lw_latency", 32'(lat), 32'd3);
    chk("lw_endereco", bus.endereco, 32'd4);
    chk("lw_data", bus.cpu_dado_lido, 32'hDEAD_BEEF);
    chk("lw_memread", 32'(nrd), 32'd1);

    // Sub-word store as read-modify-write
    acesso(1'b1, 2'b10, 1'b0, 32'h20, 32'h1122_3344, lat, nrd, nwr, erro);
    acesso(1'b1, 2'b00, 1'b0, 32'h21, 32'h1234_56AA, lat, nrd, nwr, erro);
    chk("sb_latency", 32'(lat), 32'd4);
    chk("sb_memread", 32'(nrd), 32'd1);
    chk("sb_memwrite", 32'(nwr), 32'd1);
    chk("sb_lido_unchanged", bus.cpu_dado_lido, 32'hDEAD_BEEF);
    acesso(1'b0, 2'b10, 1'b0, 32'h20, 32'h0, lat, nrd, nwr, erro);
    chk("sb_readback", bus.cpu_dado_lido, 32'h1122_AA44);

    // Sub-word loads
    acesso(1'b0, 2'b00, 1'b1, 32'h21, 32'h0, lat, nrd, nwr, erro);
    chk("lb_signed", bus.cpu_dado_lido, 32'hFFFF_FFAA);
    chk("lb_latency", 32'(lat), 32'd3);
    acesso(1'b0, 2'b00, 1'b0, 32'h21, 32'h0, lat, nrd, nwr, erro);
    chk("lb_unsigned", bus.cpu_dado_lido, 32'h0000_00AA);
    acesso(1'b0, 2'b01, 1'b1, 32'h22, 32'h0, lat, nrd, nwr, erro);
    chk("lh_hi_signed", bus.cpu_dado_lido, 32'h0000_1122);
    acesso(1'b0, 2'b01, 1'b1, 32'h20, 32'h0, lat, nrd, nwr, erro);
    chk("lh_lo_signed", bus.cpu_dado_lido, 32'hFFFF_AA44);
    acesso(1'b0, 2'b00, 1'b1, 32'h23, 32'h0, lat, nrd, nwr, erro);
    chk("lb_lane3", bus.cpu_dado_lido, 32'h0000_0011);

    // Half store into upper lane, size 11 treated as word load
    acesso(1'b1, 2'b01, 1'b0, 32'h22, 32'h7777_BEEF, lat, nrd, nwr, erro);
    chk("sh_latency", 32'(lat), 32'd4);
    acesso(1'b0, 2'b11, 1'b0, 32'h20, 32'h0, lat, nrd, nwr, erro);
    chk("sh_readback", bus.cpu_dado_lido, 32'hBEEF_AA44);

    // Address wrap: 0x410 -> word 4
    acesso(1'b0, 2'b10, 1'b0, 32'h410, 32'h0, lat, nrd, nwr, erro);
    chk("wrap_endereco", bus.endereco, 32'd4);
    chk("wrap_data", bus.cpu_dado_lido, 32'hDEAD_BEEF);

    // Misaligned word load at 0x13
    acesso(1'b0, 2'b00, 1'b0, 32'h20, 32'h0, lat, nrd, nwr, erro); // lido = 0x44
    acesso(1'b0, 2'b10, 1'b0, 32'h13, 32'h0, lat, nrd, nwr, erro);
`ifdef LSU_ALINHAMENTO_EN
    chk("mis_latency", 32'(lat), 32'd1);
    chk("mis_erro", 32'(erro), 32'd1);
    chk("mis_memread", 32'(nrd), 32'd0);
    chk("mis_lido_unchanged", bus.cpu_dado_lido, 32'h0000_0044);
`else
    chk("mis_latency", 32'(lat), 32'd3);
    chk("mis_erro", 32'(erro), 32'd0);
    chk("mis_endereco", bus.endereco, 32'd4);
    chk("mis_data", bus.cpu_dado_lido, 32'hDEAD_BEEF);
`endif

    // cpu_req held high: word loads every 4th edge
    @(negedge clock);
    bus.cpu_req = 1'b1; bus.cpu_escrita = 1'b0; bus.cpu_tamanho = 2'b10;
    bus.cpu_endereco = 32'h10;
    acc = 0; npr = 0; ocup_ant = bus.cpu_ocupado;
    repeat (16) begin
      @(negedge clock);
      if (bus.cpu_ocupado && !ocup_ant) acc++;
      npr += int'(bus.cpu_pronto);
      ocup_ant = bus.cpu_ocupado;
    end
    bus.cpu_req = 1'b0;
    chk("b2b_accepts", 32'(acc), 32'd4);
    chk("b2b_pronto", 32'(npr), 32'd4);
    for (int i = 0; i < 10 && bus.cpu_ocupado; i++) @(negedge clock);
    chk("b2b_idle", 32'(bus.cpu_ocupado), 32'd0);
    chk("no_overlap", 32'(sobrepos), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
    $finish;
  end
endmodule
